// File: rtl/motor_pkg.sv
// Shared types and constants for the motor command path: drive directions,
// the UART frame header and the scheduler state encoding.
package motor_pkg;

    typedef enum logic [2:0] {
        STOP     = 3'd0,
        FORWARD  = 3'd1,
        BACKWARD = 3'd2,
        LEFT     = 3'd3,
        RIGHT    = 3'd4
    } direction_e;

    localparam logic [7:0] FRAME_HEADER = 8'hA5;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HDR  = 3'd1,
        CMD  = 3'd2,
        CSUM = 3'd3,
        GAP  = 3'd4
    } sched_state_e;

    function automatic logic [7:0] pack_cmd(input logic [2:0] dir, input logic [2:0] spd);
        return {dir, spd, 2'b00};
    endfunction

endpackage

// File: rtl/cmd_arbiter.sv
// Picks manual or autonomous drive request and applies the e-stop and
// obstacle overrides, producing the packed command byte.
module cmd_arbiter
    import motor_pkg::*;
#(
    parameter logic [7:0] TOO_CLOSE = 8'd20
) (
    input  logic [2:0] auto_direction,
    input  logic [2:0] auto_speed,
    input  logic       manual_en,
    input  logic [2:0] manual_direction,
    input  logic [2:0] manual_speed,
    input  logic       stop_latched,
    input  logic [7:0] distance,
    output logic [7:0] cmd,
    output logic       source_manual_next
);

    logic [2:0] sel_dir;
    logic [2:0] sel_spd;
    logic [2:0] eff_dir;
    logic [2:0] eff_spd;
    logic       blocked;

    always_comb begin
        sel_dir = manual_en ? manual_direction : auto_direction;
        sel_spd = manual_en ? manual_speed : auto_speed;

        // Only forward motion is blocked; reversing or turning away stays allowed.
        blocked = (distance < TOO_CLOSE) && (sel_dir == FORWARD);

        eff_dir = sel_dir;
        eff_spd = sel_spd;
        if (stop_latched || blocked) begin
            eff_dir = STOP;
            eff_spd = 3'd0;
        end

        cmd                = pack_cmd(eff_dir, eff_spd);
        source_manual_next = manual_en;
    end

endmodule

// File: rtl/motor_cmd_scheduler.sv
// Sends 3-byte motor command frames over a byte UART whenever the effective
// command changes or the keep-alive period expires, with an idle gap per frame.
module motor_cmd_scheduler
    import motor_pkg::*;
#(
    parameter int unsigned REFRESH_CYCLES = 2_500_000,
    parameter int unsigned GAP_CYCLES     = 5000,
    parameter logic [7:0]  TOO_CLOSE      = 8'd20
) (
    input  logic       CLOCK_50,
    input  logic       reset_n,
    input  logic [2:0] auto_direction,
    input  logic [2:0] auto_speed,
    input  logic       manual_en,
    input  logic [2:0] manual_direction,
    input  logic [2:0] manual_speed,
    input  logic       estop,
    input  logic       estop_clear,
    input  logic [7:0] distance,
    input  logic       tx_ready,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    output logic       busy,
    output logic       source_manual,
    output logic       stop_latched
);

    localparam int unsigned RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [RW-1:0] RefreshLast = RW'(REFRESH_CYCLES - 1);
    localparam logic [GW-1:0] GapLast     = GW'(GAP_CYCLES - 1);

    sched_state_e  state_q, state_d;
    logic [7:0]    last_cmd_q, last_cmd_d;
    logic          src_q, src_d;
    logic          stop_q, stop_d;
    logic [RW-1:0] refresh_q, refresh_d;
    logic [GW-1:0] gap_q, gap_d;

    logic [7:0] cmd;
    logic       source_manual_next;
    logic       launch;

    cmd_arbiter #(
        .TOO_CLOSE (TOO_CLOSE)
    ) u_arbiter (
        .auto_direction     (auto_direction),
        .auto_speed         (auto_speed),
        .manual_en          (manual_en),
        .manual_direction   (manual_direction),
        .manual_speed       (manual_speed),
        .stop_latched       (stop_q),
        .distance           (distance),
        .cmd                (cmd),
        .source_manual_next (source_manual_next)
    );

    // Next-state logic; tx_valid is high in every byte state, so acceptance is tx_ready.
    always_comb begin
        state_d    = state_q;
        gap_d      = gap_q;
        launch     = 1'b0;
        last_cmd_d = last_cmd_q;
        src_d      = src_q;

        unique case (state_q)
            IDLE: begin
                if ((cmd != last_cmd_q) || (refresh_q == RefreshLast)) begin
                    state_d    = HDR;
                    launch     = 1'b1;
                    last_cmd_d = cmd;
                    src_d      = source_manual_next;
                end
            end
            HDR: begin
                if (tx_ready) state_d = CMD;
            end
            CMD: begin
                if (tx_ready) state_d = CSUM;
            end
            CSUM: begin
                if (tx_ready) begin
                    state_d = GAP;
                    gap_d   = '0;
                end
            end
            GAP: begin
                if (gap_q == GapLast) begin
                    state_d = IDLE;
                    gap_d   = '0;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (launch) begin
            refresh_d = '0;
        end else if (refresh_q == RefreshLast) begin
            refresh_d = refresh_q;
        end else begin
            refresh_d = refresh_q + 1'b1;
        end

        // A simultaneous set and clear keeps the stop engaged.
        if (estop) begin
            stop_d = 1'b1;
        end else if (estop_clear) begin
            stop_d = 1'b0;
        end else begin
            stop_d = stop_q;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            last_cmd_q <= 8'hFF;
            src_q      <= 1'b0;
            stop_q     <= 1'b0;
            refresh_q  <= '0;
            gap_q      <= '0;
        end else begin
            state_q    <= state_d;
            last_cmd_q <= last_cmd_d;
            src_q      <= src_d;
            stop_q     <= stop_d;
            refresh_q  <= refresh_d;
            gap_q      <= gap_d;
        end
    end

    // Frame bytes come from the latched command, so input changes cannot disturb a frame.
    always_comb begin
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        unique case (state_q)
            HDR: begin
                tx_valid = 1'b1;
                tx_data  = FRAME_HEADER;
            end
            CMD: begin
                tx_valid = 1'b1;
                tx_data  = last_cmd_q;
            end
            CSUM: begin
                tx_valid = 1'b1;
                tx_data  = FRAME_HEADER ^ last_cmd_q;
            end
            default: begin
                tx_valid = 1'b0;
                tx_data  = 8'h00;
            end
        endcase
    end

    assign busy          = (state_q != IDLE);
    assign source_manual = src_q;
    assign stop_latched  = stop_q;

endmodule

// File: tb/tb_motor_cmd_scheduler.sv
// Scoreboard bench for motor_cmd_scheduler: stimulus queues expected frame
// bytes, a negedge monitor checks every accepted byte, stalls and gap length.
module tb_motor_cmd_scheduler;

    localparam int unsigned REFRESH = 300;
    localparam int unsigned GAP     = 20;

    logic       CLOCK_50 = 1'b0;
    logic       reset_n;
    logic [2:0] auto_direction, auto_speed, manual_direction, manual_speed;
    logic       manual_en, estop, estop_clear, tx_ready;
    logic [7:0] distance;
    logic [7:0] tx_data;
    logic       tx_valid, busy, source_manual, stop_latched;

    motor_cmd_scheduler #(
        .REFRESH_CYCLES (REFRESH),
        .GAP_CYCLES     (GAP),
        .TOO_CLOSE      (8'd20)
    ) dut (
        .CLOCK_50         (CLOCK_50),
        .reset_n          (reset_n),
        .auto_direction   (auto_direction),
        .auto_speed       (auto_speed),
        .manual_en        (manual_en),
        .manual_direction (manual_direction),
        .manual_speed     (manual_speed),
        .estop            (estop),
        .estop_clear      (estop_clear),
        .distance         (distance),
        .tx_ready         (tx_ready),
        .tx_data          (tx_data),
        .tx_valid         (tx_valid),
        .busy             (busy),
        .source_manual    (source_manual),
        .stop_latched     (stop_latched)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    logic [7:0] exp_q[$];
    int         hdr_cyc[$];

    always @(posedge CLOCK_50) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor
    int         byte_idx   = 0;
    int         gap_len    = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data  = 8'h00;

    always @(negedge CLOCK_50) begin
        if (prev_stall && reset_n) begin
            check("stall_valid_held", {31'd0, tx_valid}, 32'd1);
            check("stall_data_stable", {24'd0, tx_data}, {24'd0, prev_data});
        end
        prev_stall = reset_n && tx_valid && !tx_ready;
        prev_data  = tx_data;

        if (reset_n && tx_valid && tx_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_byte: got %0h with nothing expected (cycle %0d)",
                         tx_data, cyc);
            end else begin
                check("tx_byte", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
            end
            if (byte_idx == 0) hdr_cyc.push_back(cyc);
            byte_idx = (byte_idx == 2) ? 0 : byte_idx + 1;
        end

        if (busy && !tx_valid) begin
            gap_len++;
        end else if (!busy && gap_len > 0) begin
            check("gap_length", gap_len, GAP);
            gap_len = 0;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLOCK_50);
        #1;
    endtask

    task automatic push_frame(input logic [7:0] c);
        exp_q.push_back(8'hA5);
        exp_q.push_back(c);
        exp_q.push_back(8'hA5 ^ c);
    endtask

    task automatic wait_idle(input int bound);
        int i;
        i = 0;
        @(negedge CLOCK_50);
        while (!(busy == 1'b0 && exp_q.size() == 0) && i < bound) begin
            @(negedge CLOCK_50);
            i++;
        end
        if (i >= bound) begin
            n_cmp++;
            n_err++;
            $display("FAIL idle_timeout: got %0d bytes pending, busy=%0b, required 0 and idle",
                     exp_q.size(), busy);
            exp_q.delete();
        end
        @(posedge CLOCK_50);
        #1;
    endtask

    // Returns just after the edge that accepts the header byte.
    task automatic wait_hdr(input int bound);
        int i;
        i = 0;
        @(negedge CLOCK_50);
        while (!(tx_valid && tx_data == 8'hA5) && i < bound) begin
            @(negedge CLOCK_50);
            i++;
        end
        if (i >= bound) begin
            n_cmp++;
            n_err++;
            $display("FAIL hdr_timeout: got no header within %0d cycles, required one", bound);
        end
        @(posedge CLOCK_50);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got simulation still running, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        int c0;
        reset_n          = 1'b0;
        auto_direction   = 3'd1;
        auto_speed       = 3'd3;
        manual_en        = 1'b0;
        manual_direction = 3'd0;
        manual_speed     = 3'd0;
        estop            = 1'b0;
        estop_clear      = 1'b0;
        distance         = 8'd100;
        tx_ready         = 1'b1;
        tick(3);
        check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        check("rst_tx_data", {24'd0, tx_data}, 32'h00);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_stop", {31'd0, stop_latched}, 32'd0);
        check("rst_src", {31'd0, source_manual}, 32'd0);

        // Post-reset frame with the cmd byte stalled for 10 cycles.
        push_frame(8'h2C);
        reset_n = 1'b1;
        wait_hdr(20);
        tx_ready = 1'b0;
        repeat (10) begin
            @(negedge CLOCK_50);
            check("cmd_stall_valid", {31'd0, tx_valid}, 32'd1);
            check("cmd_stall_data", {24'd0, tx_data}, 32'h2C);
        end
        @(posedge CLOCK_50);
        #1;
        tx_ready = 1'b1;
        wait_idle(200);

        // Manual takes over, with one-cycle reaction latency.
        manual_en        = 1'b1;
        manual_direction = 3'd3;
        manual_speed     = 3'd2;
        c0               = cyc;
        push_frame(8'h68);
        wait_idle(200);
        check("react_latency", hdr_cyc[hdr_cyc.size()-1] - c0, 1);
        check("src_manual", {31'd0, source_manual}, 32'd1);

        manual_en = 1'b0;
        push_frame(8'h2C);
        wait_idle(200);
        check("src_auto", {31'd0, source_manual}, 32'd0);

        // Obstacle threshold: 19 blocks, 20 does not.
        distance = 8'd19;
        push_frame(8'h00);
        wait_idle(200);
        distance = 8'd20;
        push_frame(8'h2C);
        wait_idle(200);

        // E-stop during a stalled cmd byte: frame completes, STOP frame follows.
        auto_direction = 3'd4;
        auto_speed     = 3'd7;
        push_frame(8'h9C);
        push_frame(8'h00);
        wait_hdr(20);
        tx_ready = 1'b0;
        tick(2);
        estop = 1'b1;
        tick(1);
        estop = 1'b0;
        check("estop_latched", {31'd0, stop_latched}, 32'd1);
        tick(2);
        tx_ready = 1'b1;
        wait_idle(400);
        check("estop_held", {31'd0, stop_latched}, 32'd1);

        estop       = 1'b1;
        estop_clear = 1'b1;
        tick(1);
        estop       = 1'b0;
        estop_clear = 1'b0;
        check("estop_wins", {31'd0, stop_latched}, 32'd1);
        tick(5);
        check("no_frame_while_stopped", {31'd0, busy}, 32'd0);

        push_frame(8'h9C);
        estop_clear = 1'b1;
        tick(1);
        estop_clear = 1'b0;
        check("estop_cleared", {31'd0, stop_latched}, 32'd0);
        wait_idle(200);

        // Reset in the middle of a frame abandons it.
        tx_ready       = 1'b0;
        auto_direction = 3'd2;
        auto_speed     = 3'd1;
        tick(3);
        check("midframe_valid", {31'd0, tx_valid}, 32'd1);
        check("midframe_hdr", {24'd0, tx_data}, 32'hA5);
        reset_n = 1'b0;
        tick(1);
        check("midreset_valid", {31'd0, tx_valid}, 32'd0);
        check("midreset_busy", {31'd0, busy}, 32'd0);
        tick(2);
        push_frame(8'h44);
        tx_ready = 1'b1;
        reset_n  = 1'b1;
        wait_idle(200);

        // Keep-alive: two identical frames exactly REFRESH cycles apart.
        push_frame(8'h44);
        push_frame(8'h44);
        wait_idle(3 * REFRESH);
        check("refresh_period",
              hdr_cyc[hdr_cyc.size()-1] - hdr_cyc[hdr_cyc.size()-2], REFRESH);
        tick(50);
        check("queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
